// File: rtl/mem_write_checker.sv
// Snoops the core's data-memory write port and checks stores against a
// preloaded program-order queue of expected (address, data) pairs.
module mem_write_checker #(
  parameter int               ADDR_W      = 32,
  parameter int               DATA_W      = 32,
  parameter int               DEPTH       = 4,
  parameter int               TIMEOUT     = 1024,
  parameter bit               IGNORE_EN   = 1'b1,
  parameter logic [ADDR_W-1:0] IGNORE_ADDR = ADDR_W'(80),
  parameter bit               ORDERED     = 1'b1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic                       exp_wr,
  input  logic [ADDR_W-1:0]          exp_addr,
  input  logic [DATA_W-1:0]          exp_data,
  output logic                       exp_full,
  input  logic                       mem_we,
  input  logic [ADDR_W-1:0]          mem_addr,
  input  logic [DATA_W-1:0]          mem_wdata,
  output logic                       done,
  output logic                       pass,
  output logic                       fail,
  output logic                       timeout,
  output logic [ADDR_W-1:0]          fail_addr,
  output logic [DATA_W-1:0]          fail_data,
  output logic [$clog2(DEPTH+1)-1:0] match_cnt
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int TMR_W = $clog2(TIMEOUT + 1);
  localparam int ENT_W = ADDR_W + DATA_W;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RUN,
    S_PASS,
    S_FAIL,
    S_TIMEOUT
  } state_t;

  state_t             state_q, state_d;
  logic [ENT_W-1:0]   q_mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr, rd_ptr;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [TMR_W-1:0]   timer_q, timer_d;
  logic [ENT_W-1:0]   head;
  logic               push, pop, latch_fail;
  logic               ignore_hit, head_hit;

  assign head       = q_mem[rd_ptr];
  assign ignore_hit = IGNORE_EN && (mem_addr == IGNORE_ADDR);
  // X/Z on the snooped bus makes this unknown, which takes the mismatch branch below.
  assign head_hit   = ({mem_addr, mem_wdata} == head);

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
    state_d    = state_q;
    timer_d    = timer_q;
    push       = 1'b0;
    pop        = 1'b0;
    latch_fail = 1'b0;
    case (state_q)
      S_IDLE: begin
        push = exp_wr && (count_q != CNT_W'(DEPTH));
        if (start) begin
          timer_d = '0;
          state_d = (count_q == '0) ? S_PASS : S_RUN;
        end
      end
      S_RUN: begin
        timer_d = timer_q + TMR_W'(1);
        if (mem_we && !ignore_hit) begin
          if (head_hit) begin
            pop = 1'b1;
            if (count_q == CNT_W'(1)) state_d = S_PASS;
          end else if (ORDERED) begin
            state_d    = S_FAIL;
            latch_fail = 1'b1;
          end
        end
        // A store resolving on the last allowed cycle wins over the timeout.
        if (state_d == S_RUN && timer_q == TMR_W'(TIMEOUT - 1)) state_d = S_TIMEOUT;
      end
      default: ;
    endcase

    count_d = count_q;
    if (push)     count_d = count_q + CNT_W'(1);
    else if (pop) count_d = count_q - CNT_W'(1);
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count_q   <= '0;
      timer_q   <= '0;
      match_cnt <= '0;
      exp_full  <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      fail      <= 1'b0;
      timeout   <= 1'b0;
      fail_addr <= '0;
      fail_data <= '0;
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      count_q  <= count_d;
      exp_full <= (count_d == CNT_W'(DEPTH));
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop) begin
        rd_ptr    <= rd_ptr + PTR_W'(1);
        match_cnt <= match_cnt + CNT_W'(1);
      end
      done    <= (state_d == S_PASS) || (state_d == S_FAIL) || (state_d == S_TIMEOUT);
      pass    <= (state_d == S_PASS);
      fail    <= (state_d == S_FAIL);
      timeout <= (state_d == S_TIMEOUT);
      if (latch_fail) begin
        fail_addr <= mem_addr;
        fail_data <= mem_wdata;
      end
    end
  end

  // NOTE: queue storage is not reset; only entries between the pointers are ever read.
  always_ff @(posedge clk) begin
    if (push) q_mem[wr_ptr] <= {exp_addr, exp_data};
  end

endmodule

// File: tb/tb_mem_write_checker.sv
// Randomized scoreboard bench: ordered and unordered checkers share one stimulus
// stream and are compared against a queue-based reference model.
module tb_mem_write_checker;

  localparam int DEPTH = 4;
  localparam int TMO   = 16;

  typedef struct packed { logic [31:0] addr; logic [31:0] data; } entry_t;
  typedef struct packed { logic we; logic [31:0] addr; logic [31:0] data; } store_t;
  typedef struct packed {
    logic        pass;
    logic        fail;
    logic        tmo;
    logic [31:0] fa;
    logic [31:0] fd;
    logic [2:0]  cnt;
    logic [31:0] lat;
  } result_t;

  logic        clk = 1'b0, rst = 1'b0, start = 1'b0, exp_wr = 1'b0, mem_we = 1'b0;
  logic [31:0] exp_addr = '0, exp_data = '0, mem_addr = '0, mem_wdata = '0;
  logic        exp_full [2];
  logic        done [2];
  logic        pass [2];
  logic        fail [2];
  logic        tmo [2];
  logic [31:0] fail_addr [2];
  logic [31:0] fail_data [2];
  logic [2:0]  match_cnt [2];

  int n_tests = 0, n_fail = 0;
  int cyc = 0, start_cyc = 0;
  result_t sb0[$], sb1[$];

  always #5 clk = ~clk;

  mem_write_checker #(.ADDR_W(32), .DATA_W(32), .DEPTH(DEPTH), .TIMEOUT(TMO),
    .IGNORE_EN(1'b1), .IGNORE_ADDR(32'd80), .ORDERED(1'b1)) u_ord (
    .clk(clk), .rst(rst), .start(start), .exp_wr(exp_wr), .exp_addr(exp_addr),
    .exp_data(exp_data), .exp_full(exp_full[0]), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .done(done[0]), .pass(pass[0]), .fail(fail[0]),
    .timeout(tmo[0]), .fail_addr(fail_addr[0]), .fail_data(fail_data[0]),
    .match_cnt(match_cnt[0]));

  mem_write_checker #(.ADDR_W(32), .DATA_W(32), .DEPTH(DEPTH), .TIMEOUT(TMO),
    .IGNORE_EN(1'b1), .IGNORE_ADDR(32'd80), .ORDERED(1'b0)) u_unord (
    .clk(clk), .rst(rst), .start(start), .exp_wr(exp_wr), .exp_addr(exp_addr),
    .exp_data(exp_data), .exp_full(exp_full[1]), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .done(done[1]), .pass(pass[1]), .fail(fail[1]),
    .timeout(tmo[1]), .fail_addr(fail_addr[1]), .fail_data(fail_data[1]),
    .match_cnt(match_cnt[1]));

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic entry_t mk_e(input int a, input int d);
    mk_e.addr = 32'(a);
    mk_e.data = 32'(d);
  endfunction

  function automatic store_t mk_s(input int a, input int d);
    mk_s.we   = 1'b1;
    mk_s.addr = 32'(a);
    mk_s.data = 32'(d);
  endfunction

  // Reference: queue holds at most DEPTH pushes; each RUN cycle's store is
  // judged against the front of the queue; cycle index c resolves at edge c+1.
  function automatic result_t model(input entry_t pushes[$], input store_t st[$], input bit ordered);
    entry_t  q[$];
    result_t r;
    r = '0;
    foreach (pushes[i]) if (q.size() < DEPTH) q.push_back(pushes[i]);
    if (q.size() == 0) begin
      r.pass = 1'b1;
      return r;
    end
    for (int c = 0; c < TMO; c++) begin
      if (st[c].we && st[c].addr != 32'd80) begin
        if (st[c].addr == q[0].addr && st[c].data == q[0].data) begin
          q.delete(0);
          r.cnt = r.cnt + 3'd1;
          if (q.size() == 0) begin
            r.pass = 1'b1;
            r.lat  = 32'(c + 1);
            return r;
          end
        end else if (ordered) begin
          r.fail = 1'b1;
          r.fa   = st[c].addr;
          r.fd   = st[c].data;
          r.lat  = 32'(c + 1);
          return r;
        end
      end
    end
    r.tmo = 1'b1;
    r.lat = 32'(TMO);
    return r;
  endfunction

  // Monitor: pops the scoreboard on each rising done, then watches for stickiness.
  initial begin
    bit      prev [2];
    result_t snap [2];
    result_t got, want;
    prev[0] = 1'b0;
    prev[1] = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      for (int d = 0; d < 2; d++) begin
        got.pass = pass[d];
        got.fail = fail[d];
        got.tmo  = tmo[d];
        got.fa   = fail_addr[d];
        got.fd   = fail_data[d];
        got.cnt  = match_cnt[d];
        got.lat  = 32'(cyc - start_cyc);
        if (done[d] && !prev[d]) begin
          if ((d == 0 ? sb0.size() : sb1.size()) == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_done[%0d]: got done=1, expected no result pending", d);
          end else begin
            if (d == 0) want = sb0.pop_front();
            else        want = sb1.pop_front();
            check($sformatf("result[%0d]", d), 128'(got), 128'(want));
            snap[d] = got;
          end
        end else if (done[d]) begin
          got.lat     = '0;
          snap[d].lat = '0;
          check($sformatf("sticky[%0d]", d), 128'(got), 128'(snap[d]));
          check($sformatf("onehot[%0d]", d), 128'(pass[d] + fail[d] + tmo[d]), 128'(1));
        end
        prev[d] = done[d];
      end
    end
  end

  task automatic check_reset_outputs(input string tag);
    for (int d = 0; d < 2; d++)
      check($sformatf("%s[%0d]", tag, d),
            {exp_full[d], done[d], pass[d], fail[d], tmo[d], fail_addr[d], fail_data[d], match_cnt[d]},
            128'(0));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst    = 1'b0;
    start  = 1'b0;
    exp_wr = 1'b0;
    mem_we = 1'b0;
    #1;
    check_reset_outputs("reset_out");
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic load(input entry_t pushes[$]);
    for (int i = 0; i < pushes.size(); i++) begin
      @(negedge clk);
      if (i > 0) begin
        check("exp_full0", 128'(exp_full[0]), 128'(i >= DEPTH));
        check("exp_full1", 128'(exp_full[1]), 128'(i >= DEPTH));
      end
      exp_wr   = 1'b1;
      exp_addr = pushes[i].addr;
      exp_data = pushes[i].data;
    end
    @(negedge clk);
    exp_wr = 1'b0;
    if (pushes.size() > 0) begin
      check("exp_full0", 128'(exp_full[0]), 128'(pushes.size() >= DEPTH));
      check("exp_full1", 128'(exp_full[1]), 128'(pushes.size() >= DEPTH));
    end
  endtask

  task automatic run_scenario(input entry_t pushes[$], input store_t st[$]);
    do_reset();
    while (st.size() < TMO + 2) st.push_back('0);
    load(pushes);
    sb0.push_back(model(pushes, st, 1'b1));
    sb1.push_back(model(pushes, st, 1'b0));
    // A store coinciding with start must not be evaluated.
    start     = 1'b1;
    mem_we    = 1'b1;
    mem_addr  = (pushes.size() > 0) ? pushes[0].addr : 32'd84;
    mem_wdata = (pushes.size() > 0) ? pushes[0].data : 32'd7;
    start_cyc = cyc + 1;
    for (int c = 0; c < TMO + 2; c++) begin
      @(negedge clk);
      start     = 1'b0;
      mem_we    = st[c].we;
      mem_addr  = st[c].addr;
      mem_wdata = st[c].data;
    end
    @(negedge clk);
    mem_we = 1'b0;
    repeat (2) @(negedge clk);
    check("sb_drain", 128'(sb0.size() + sb1.size()), 128'(0));
    sb0.delete();
    sb1.delete();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no end of run, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    entry_t p[$];
    store_t s[$];
    int     n, ptr, r;

    p = '{mk_e(84, 7)};
    s = '{mk_s(80, 3), mk_s(84, 7)};
    run_scenario(p, s);

    s = '{mk_s(84, 6), mk_s(84, 7)};
    run_scenario(p, s);

    p = '{mk_e(84, 7), mk_e(88, 9)};
    s = '{mk_s(88, 9), mk_s(84, 7), mk_s(88, 9)};
    run_scenario(p, s);
    s = '{mk_s(84, 7), mk_s(88, 9)};
    run_scenario(p, s);

    p = '{mk_e(84, 7)};
    s = {};
    run_scenario(p, s);
    s = {};
    for (int i = 0; i < TMO - 1; i++) s.push_back('0);
    s.push_back(mk_s(84, 7));
    run_scenario(p, s);

    p = '{mk_e(84, 1), mk_e(88, 2), mk_e(92, 3), mk_e(96, 4), mk_e(100, 5)};
    s = '{mk_s(84, 1), mk_s(88, 2), mk_s(92, 3), mk_s(96, 4)};
    run_scenario(p, s);

    p = {};
    s = '{mk_s(84, 7)};
    run_scenario(p, s);

    // Reset asserted mid-RUN, between clock edges, after one of two matches.
    do_reset();
    p = '{mk_e(84, 7), mk_e(88, 9)};
    load(p);
    start = 1'b1;
    start_cyc = cyc + 1;
    @(negedge clk);
    start     = 1'b0;
    mem_we    = 1'b1;
    mem_addr  = 32'd84;
    mem_wdata = 32'd7;
    @(negedge clk);
    mem_we = 1'b0;
    check("mid_cnt0", 128'(match_cnt[0]), 128'(1));
    check("mid_cnt1", 128'(match_cnt[1]), 128'(1));
    #2;
    rst = 1'b0;
    #1;
    check_reset_outputs("async_rst");
    @(negedge clk);
    rst = 1'b1;
    s = '{mk_s(84, 7), mk_s(80, 1), mk_s(88, 9)};
    run_scenario(p, s);

    for (int it = 0; it < 40; it++) begin
      p = {};
      s = {};
      n = $urandom_range(0, 5);
      for (int i = 0; i < n; i++)
        p.push_back(mk_e(84 + 4 * $urandom_range(0, 3), $urandom_range(0, 3)));
      ptr = 0;
      for (int c = 0; c < TMO + 2; c++) begin
        r = $urandom_range(0, 99);
        if (r < 45 && ptr < n && ptr < DEPTH) begin
          s.push_back(mk_s(p[ptr].addr, p[ptr].data));
          ptr++;
        end else if (r < 65) begin
          s.push_back('{1'b0, 32'($urandom_range(80, 100)), 32'($urandom_range(0, 3))});
        end else if (r < 80) begin
          s.push_back(mk_s(80, $urandom_range(0, 3)));
        end else begin
          s.push_back(mk_s(84 + 4 * $urandom_range(0, 3), $urandom_range(0, 3)));
        end
      end
      run_scenario(p, s);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
